// File: rtl/sha2_msg_schedule_if.sv
// ============================================================================
// sha2_msg_schedule_if : message-block load and schedule-word output bundle
// Rev 1.0
// ============================================================================
`default_nettype none

interface sha2_msg_schedule_if;
  logic        mode_sha2;
  logic        start;
  logic        blk_valid;
  logic [63:0] blk_word;
  logic        blk_ready;
  logic        w_valid;
  logic [63:0] w_out;
  logic        w_ready;
  logic [6:0]  round;
  logic        busy;
  logic        done;

  modport master (
    output mode_sha2, start, blk_valid, blk_word, w_ready,
    input  blk_ready, w_valid, w_out, round, busy, done
  );

  modport slave (
    input  mode_sha2, start, blk_valid, blk_word, w_ready,
    output blk_ready, w_valid, w_out, round, busy, done
  );
endinterface

`default_nettype wire

// File: rtl/sha2_msg_schedule.sv
// ============================================================================
// sha2_msg_schedule : SHA-256/SHA-512 message expansion on a 16x64 window
// Rev 1.0
// ============================================================================
`default_nettype none

module sha2_msg_schedule (
  input  logic                clk,
  input  logic                rst_n,
  sha2_msg_schedule_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic        r_mode;
  logic [3:0]  r_cnt;
  logic [6:0]  r_round;
  logic [63:0] r_win [0:15];

  logic        w_blk_acc;
  logic        w_w_acc;
  logic [6:0]  w_last_round;
  logic [31:0] w_sum256;
  logic [63:0] w_sum512;
  logic [63:0] w_new;

  function automatic logic [31:0] f_s0_256(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
  endfunction

  function automatic logic [31:0] f_s1_256(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
  endfunction

  function automatic logic [63:0] f_s0_512(input logic [63:0] x);
    return {x[0], x[63:1]} ^ {x[7:0], x[63:8]} ^ (x >> 7);
  endfunction

  function automatic logic [63:0] f_s1_512(input logic [63:0] x);
    return {x[18:0], x[63:19]} ^ {x[60:0], x[63:61]} ^ (x >> 6);
  endfunction

  assign w_blk_acc    = (r_state == S_LOAD) && bus.blk_valid;
  assign w_w_acc      = (r_state == S_RUN) && bus.w_ready;
  assign w_last_round = r_mode ? 7'd79 : 7'd63;

  // Window taps: W[t-16]=win[0], W[t-15]=win[1], W[t-7]=win[9], W[t-2]=win[14]
  assign w_sum256 = f_s1_256(r_win[14][31:0]) + r_win[9][31:0]
                  + f_s0_256(r_win[1][31:0])  + r_win[0][31:0];
  assign w_sum512 = f_s1_512(r_win[14]) + r_win[9] + f_s0_512(r_win[1]) + r_win[0];
  assign w_new    = r_mode ? w_sum512 : {32'h0, w_sum256};

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (bus.start) w_next = S_LOAD;
      S_LOAD:  if (w_blk_acc && (r_cnt == 4'd15)) w_next = S_RUN;
      S_RUN:   if (w_w_acc && (r_round == w_last_round)) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mode  <= 1'b0;
      r_cnt   <= 4'd0;
      r_round <= 7'd0;
      for (int i = 0; i < 16; i++) begin
        r_win[i] <= 64'h0;
      end
    end else begin
      if ((r_state == S_IDLE) && bus.start) begin
        r_mode  <= bus.mode_sha2;
        r_cnt   <= 4'd0;
        r_round <= 7'd0;
      end
      if (w_blk_acc) begin
        r_win[r_cnt] <= r_mode ? bus.blk_word : {32'h0, bus.blk_word[31:0]};
        r_cnt        <= r_cnt + 4'd1;
      end
      if (w_w_acc) begin
        for (int i = 0; i < 15; i++) begin
          r_win[i] <= r_win[i+1];
        end
        r_win[15] <= w_new;
        r_round   <= r_round + 7'd1;
      end
    end
  end

  assign bus.blk_ready = (r_state == S_LOAD);
  assign bus.w_valid   = (r_state == S_RUN);
  assign bus.w_out     = (r_state == S_RUN) ? r_win[0] : 64'h0;
  assign bus.round     = r_round;
  assign bus.busy      = (r_state == S_LOAD) || (r_state == S_RUN);
  assign bus.done      = (r_state == S_DONE);

endmodule

`default_nettype wire

// File: tb/tb_sha2_msg_schedule.sv
// ============================================================================
// tb_sha2_msg_schedule : randomized bench against a textbook W_t reference
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_sha2_msg_schedule;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  sha2_msg_schedule_if bus();

  sha2_msg_schedule dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [63:0] blk   [16];
  logic [63:0] ref_w [80];
  logic [63:0] obs_w [$];
  int          obs_r [$];
  int          stall_bad, invalid_bad, done_cnt, first_bad;
  bit          done_end, timeout, aborted;

  function automatic logic [31:0] rotr32(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [63:0] rotr64(input logic [63:0] x, input int n);
    return (x >> n) | (x << (64 - n));
  endfunction

  // Reference: W_t = s1(W_{t-2}) + W_{t-7} + s0(W_{t-15}) + W_{t-16}
  task automatic compute_ref(input bit mode);
    logic [31:0] a32, b32;
    logic [63:0] a64, b64;
    for (int t = 0; t < 80; t++) begin
      if (t < 16) begin
        ref_w[t] = mode ? blk[t] : {32'h0, blk[t][31:0]};
      end else if (mode) begin
        a64 = rotr64(ref_w[t-2], 19) ^ rotr64(ref_w[t-2], 61) ^ (ref_w[t-2] >> 6);
        b64 = rotr64(ref_w[t-15], 1) ^ rotr64(ref_w[t-15], 8) ^ (ref_w[t-15] >> 7);
        ref_w[t] = a64 + ref_w[t-7] + b64 + ref_w[t-16];
      end else begin
        a32 = rotr32(ref_w[t-2][31:0], 17) ^ rotr32(ref_w[t-2][31:0], 19) ^ (ref_w[t-2][31:0] >> 10);
        b32 = rotr32(ref_w[t-15][31:0], 7) ^ rotr32(ref_w[t-15][31:0], 18) ^ (ref_w[t-15][31:0] >> 3);
        ref_w[t] = {32'h0, a32 + ref_w[t-7][31:0] + b32 + ref_w[t-16][31:0]};
      end
    end
  endtask

  // Drives one block and records what the DUT produced; comparisons happen in callers.
  task automatic run_block(input bit mode, input int pv, input int pr,
                           input bit stray, input int abort_round);
    int          idx, guard, n, got;
    bit          acc, rdy, stalled;
    logic [63:0] hold_w;
    logic [6:0]  hold_r;
    obs_w.delete(); obs_r.delete();
    stall_bad = 0; invalid_bad = 0; done_cnt = 0; first_bad = 0;
    done_end = 0; timeout = 0; aborted = 0;
    hold_w = '0; hold_r = '0;
    @(negedge clk);
    bus.start = 1'b1; bus.mode_sha2 = mode;
    @(negedge clk);
    bus.start = 1'b0;
    if (bus.blk_ready !== 1'b1) first_bad++;
    idx = 0; guard = 0;
    while (idx < 16 && guard < 1000) begin
      bus.blk_valid = ($urandom_range(99) < pv);
      bus.blk_word  = bus.blk_valid ? blk[idx] : {$urandom, $urandom};
      bus.w_ready   = 1'($urandom_range(1));
      if (stray) bus.mode_sha2 = 1'($urandom_range(1));
      acc = bus.blk_ready && bus.blk_valid;
      if (bus.done) done_cnt++;
      @(negedge clk);
      guard++;
      if (acc) idx++;
    end
    if (idx < 16) timeout = 1;
    if (!timeout && bus.w_valid !== 1'b1) first_bad++;
    n = mode ? 80 : 64; got = 0; stalled = 0; guard = 0;
    while (!timeout && got < n && guard < 5000) begin
      if (abort_round >= 0 && int'(bus.round) == abort_round) begin
        aborted = 1;
        break;
      end
      if (bus.w_valid !== 1'b1) invalid_bad++;
      if (bus.done) done_cnt++;
      if (stalled && (bus.w_out !== hold_w || bus.round !== hold_r)) stall_bad++;
      rdy = ($urandom_range(99) < pr);
      bus.w_ready   = rdy;
      bus.blk_valid = 1'($urandom_range(1));
      bus.blk_word  = {$urandom, $urandom};
      if (stray) begin
        bus.start     = 1'($urandom_range(1));
        bus.mode_sha2 = 1'($urandom_range(1));
      end
      if (bus.w_valid && rdy) begin
        obs_w.push_back(bus.w_out);
        obs_r.push_back(int'(bus.round));
        got++;
        stalled = 0;
      end else begin
        stalled = 1;
        hold_w  = bus.w_out;
        hold_r  = bus.round;
      end
      @(negedge clk);
      guard++;
    end
    if (got < n && !aborted) timeout = 1;
    if (!aborted) begin
      bus.start = 1'b0; bus.w_ready = 1'b0; bus.blk_valid = 1'b0;
      done_end = bus.done;
      repeat (4) begin
        @(negedge clk);
        if (bus.done) done_cnt++;
        if (bus.busy) invalid_bad++;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({bus.blk_ready, bus.w_valid, bus.busy, bus.done} !== 4'b0) begin
      n_fail++;
      $display("FAIL reset_flags: got rdy/val/busy/done=%b, want 0000",
               {bus.blk_ready, bus.w_valid, bus.busy, bus.done});
    end
    n_checks++;
    if (bus.w_out !== 64'h0 || bus.round !== 7'd0) begin
      n_fail++;
      $display("FAIL reset_data: got w_out=%h round=%0d, want 0/0", bus.w_out, bus.round);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({bus.blk_ready, bus.w_valid, bus.busy, bus.done} !== 4'b0) begin
      n_fail++;
      $display("FAIL idle_flags: got rdy/val/busy/done=%b, want 0000",
               {bus.blk_ready, bus.w_valid, bus.busy, bus.done});
    end
  endtask

  task automatic test_sha256_abc();
    logic [63:0] g;
    foreach (blk[i]) blk[i] = 64'h0;
    blk[0] = 64'h61626380; blk[15] = 64'h18;
    compute_ref(1'b0);
    run_block(1'b0, 100, 100, 1'b0, -1);
    n_checks++;
    if (obs_w.size() != 64 || timeout) begin
      n_fail++;
      $display("FAIL abc256_count: got %0d words timeout=%0b, want 64", obs_w.size(), timeout);
    end
    foreach (obs_w[i]) begin
      n_checks++;
      if (obs_w[i] !== ref_w[i] || obs_r[i] != i) begin
        n_fail++;
        $display("FAIL abc256_w%0d: got %h round %0d, want %h round %0d", i, obs_w[i], obs_r[i], ref_w[i], i);
      end
    end
    g = (obs_w.size() > 18) ? obs_w[18] : 'x;
    n_checks++;
    if (g !== 64'h7DA86405) begin
      n_fail++;
      $display("FAIL abc256_w18_vector: got %h, want 000000007da86405", g);
    end
    g = (obs_w.size() > 17) ? obs_w[17] : 'x;
    n_checks++;
    if (g !== 64'h000F0000) begin
      n_fail++;
      $display("FAIL abc256_w17_vector: got %h, want 00000000000f0000", g);
    end
    n_checks++;
    if (done_end !== 1'b1 || done_cnt != 0 || first_bad != 0 || invalid_bad != 0) begin
      n_fail++;
      $display("FAIL abc256_timing: got done_end=%0b extra_done=%0d first_bad=%0d invalid=%0d, want 1/0/0/0",
               done_end, done_cnt, first_bad, invalid_bad);
    end
  endtask

  task automatic test_sha512_abc();
    logic [63:0] g;
    foreach (blk[i]) blk[i] = 64'h0;
    blk[0] = 64'h6162638000000000; blk[15] = 64'h18;
    compute_ref(1'b1);
    run_block(1'b1, 100, 100, 1'b0, -1);
    n_checks++;
    if (obs_w.size() != 80 || timeout) begin
      n_fail++;
      $display("FAIL abc512_count: got %0d words timeout=%0b, want 80", obs_w.size(), timeout);
    end
    foreach (obs_w[i]) begin
      n_checks++;
      if (obs_w[i] !== ref_w[i] || obs_r[i] != i) begin
        n_fail++;
        $display("FAIL abc512_w%0d: got %h round %0d, want %h round %0d", i, obs_w[i], obs_r[i], ref_w[i], i);
      end
    end
    g = (obs_w.size() > 17) ? obs_w[17] : 'x;
    n_checks++;
    if (g !== 64'h00030000000000C0) begin
      n_fail++;
      $display("FAIL abc512_w17_vector: got %h, want 00030000000000c0", g);
    end
    n_checks++;
    if (done_end !== 1'b1 || done_cnt != 0 || first_bad != 0) begin
      n_fail++;
      $display("FAIL abc512_timing: got done_end=%0b extra_done=%0d first_bad=%0d, want 1/0/0",
               done_end, done_cnt, first_bad);
    end
  endtask

  task automatic test_backpressure();
    foreach (blk[i]) blk[i] = 64'h0;
    blk[0] = 64'h61626380; blk[15] = 64'h18;
    compute_ref(1'b0);
    run_block(1'b0, 40, 45, 1'b0, -1);
    n_checks++;
    if (obs_w.size() != 64 || timeout) begin
      n_fail++;
      $display("FAIL bp_count: got %0d words timeout=%0b, want 64", obs_w.size(), timeout);
    end
    foreach (obs_w[i]) begin
      n_checks++;
      if (obs_w[i] !== ref_w[i] || obs_r[i] != i) begin
        n_fail++;
        $display("FAIL bp_w%0d: got %h round %0d, want %h round %0d", i, obs_w[i], obs_r[i], ref_w[i], i);
      end
    end
    n_checks++;
    if (stall_bad != 0 || invalid_bad != 0 || done_end !== 1'b1 || done_cnt != 0) begin
      n_fail++;
      $display("FAIL bp_stall: got unstable=%0d invalid=%0d done_end=%0b extra_done=%0d, want 0/0/1/0",
               stall_bad, invalid_bad, done_end, done_cnt);
    end
  endtask

  task automatic test_upper_mask();
    foreach (blk[i]) blk[i] = {32'hFFFFFFFF, $urandom};
    compute_ref(1'b0);
    run_block(1'b0, 70, 70, 1'b0, -1);
    n_checks++;
    if (obs_w.size() != 64 || timeout) begin
      n_fail++;
      $display("FAIL mask_count: got %0d words timeout=%0b, want 64", obs_w.size(), timeout);
    end
    foreach (obs_w[i]) begin
      n_checks++;
      if (obs_w[i][63:32] !== 32'h0 || obs_w[i] !== ref_w[i]) begin
        n_fail++;
        $display("FAIL mask_w%0d: got %h, want %h", i, obs_w[i], ref_w[i]);
      end
    end
  endtask

  task automatic test_mode_latch();
    foreach (blk[i]) blk[i] = {$urandom, $urandom};
    compute_ref(1'b0);
    run_block(1'b0, 80, 60, 1'b1, -1);
    n_checks++;
    if (obs_w.size() != 64 || timeout || done_end !== 1'b1 || done_cnt != 0) begin
      n_fail++;
      $display("FAIL latch_len: got %0d words done_end=%0b extra_done=%0d, want 64/1/0",
               obs_w.size(), done_end, done_cnt);
    end
    foreach (obs_w[i]) begin
      n_checks++;
      if (obs_w[i] !== ref_w[i] || obs_r[i] != i) begin
        n_fail++;
        $display("FAIL latch_w%0d: got %h round %0d, want %h round %0d", i, obs_w[i], obs_r[i], ref_w[i], i);
      end
    end
  endtask

  task automatic test_reset_mid();
    foreach (blk[i]) blk[i] = 64'h0;
    blk[0] = 64'h61626380; blk[15] = 64'h18;
    compute_ref(1'b0);
    run_block(1'b0, 100, 100, 1'b0, 20);
    n_checks++;
    if (!aborted) begin
      n_fail++;
      $display("FAIL rstmid_reach: got round20_reached=%0b, want 1", aborted);
    end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({bus.blk_ready, bus.w_valid, bus.busy, bus.done} !== 4'b0 ||
        bus.w_out !== 64'h0 || bus.round !== 7'd0) begin
      n_fail++;
      $display("FAIL rstmid_outputs: got flags=%b w_out=%h round=%0d, want 0000/0/0",
               {bus.blk_ready, bus.w_valid, bus.busy, bus.done}, bus.w_out, bus.round);
    end
    bus.w_ready = 1'b0; bus.blk_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    run_block(1'b0, 100, 100, 1'b0, -1);
    n_checks++;
    if (obs_w.size() != 64 || timeout || done_end !== 1'b1) begin
      n_fail++;
      $display("FAIL rstmid_rerun: got %0d words done_end=%0b, want 64/1", obs_w.size(), done_end);
    end
    foreach (obs_w[i]) begin
      n_checks++;
      if (obs_w[i] !== ref_w[i] || obs_r[i] != i) begin
        n_fail++;
        $display("FAIL rstmid_w%0d: got %h round %0d, want %h round %0d", i, obs_w[i], obs_r[i], ref_w[i], i);
      end
    end
  endtask

  task automatic test_back_to_back();
    for (int b = 0; b < 3; b++) begin
      bit m;
      m = (b != 1);
      foreach (blk[i]) blk[i] = {$urandom, $urandom};
      compute_ref(m);
      run_block(m, 90, 90, 1'b0, -1);
      n_checks++;
      if (obs_w.size() != (m ? 80 : 64) || timeout || done_end !== 1'b1 || done_cnt != 0) begin
        n_fail++;
        $display("FAIL b2b%0d_len: got %0d words done_end=%0b extra_done=%0d", b, obs_w.size(), done_end, done_cnt);
      end
      foreach (obs_w[i]) begin
        n_checks++;
        if (obs_w[i] !== ref_w[i] || obs_r[i] != i) begin
          n_fail++;
          $display("FAIL b2b%0d_w%0d: got %h round %0d, want %h round %0d", b, i, obs_w[i], obs_r[i], ref_w[i], i);
        end
      end
    end
  endtask

  initial begin
    rst_n         = 1'b0;
    bus.start     = 1'b0;
    bus.mode_sha2 = 1'b0;
    bus.blk_valid = 1'b0;
    bus.blk_word  = 64'h0;
    bus.w_ready   = 1'b0;
    test_reset();
    test_sha256_abc();
    test_sha512_abc();
    test_backpressure();
    test_upper_mask();
    test_mode_latch();
    test_reset_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
